// File: rtl/clut_prom_arbiter.sv
// clut_prom_arbiter: shares one external 8-bit memory between the CLUT PROM 3R/3S
// per-pixel fetch sequencer and the host loader write port.
module clut_prom_arbiter #(
  parameter int unsigned       MEM_AW      = 16,
  parameter logic [MEM_AW-1:0] BASE_3R     = MEM_AW'(16'h0000),
  parameter logic [MEM_AW-1:0] BASE_3S     = MEM_AW'(16'h0200),
  parameter int unsigned       MEM_LATENCY = 1
) (
  input  logic              CLK_24M,
  input  logic              CLR,
  input  logic              PIX_CE,
  input  logic [8:0]        prom_3r_addr,
  input  logic              prom_3r_ce,
  output logic [7:0]        prom_3r_data,
  input  logic [8:0]        prom_3s_addr,
  input  logic              prom_3s_ce,
  output logic [3:0]        prom_3s_data,
  input  logic              ld_req,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ack,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              overrun
);

  localparam int unsigned   CW     = $clog2(MEM_LATENCY + 2);
  localparam logic [CW-1:0] AGE_3R = CW'(MEM_LATENCY);
  localparam logic [CW-1:0] AGE_3S = CW'(MEM_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, RD3R, RD3S, WAIT, DONE, WR} state_t;
  state_t state_q, state_d;

  logic              pend_q, pend_d;
  logic [8:0]        pend_3r_addr_q, pend_3r_addr_d, pend_3s_addr_q, pend_3s_addr_d;
  logic              pend_3r_ce_q, pend_3r_ce_d, pend_3s_ce_q, pend_3s_ce_d;
  logic [8:0]        f3s_addr_q, f3s_addr_d;
  logic              f3r_ce_q, f3r_ce_d, f3s_ce_q, f3s_ce_d;
  logic [7:0]        shadow_3r_q, shadow_3r_d;
  logic [CW-1:0]     age_q, age_d;
  logic [MEM_AW-1:0] mem_addr_d;
  logic              mem_rd_d, mem_wr_d, ld_ack_d, overrun_d;
  logic [7:0]        mem_wdata_d, prom_3r_data_d;
  logic [3:0]        prom_3s_data_d;

  // A fresh strobe in IDLE supersedes a pending one.
  logic [8:0] src_3r_addr, src_3s_addr;
  logic       src_3r_ce, src_3s_ce;
  assign src_3r_addr = PIX_CE ? prom_3r_addr : pend_3r_addr_q;
  assign src_3s_addr = PIX_CE ? prom_3s_addr : pend_3s_addr_q;
  assign src_3r_ce   = PIX_CE ? prom_3r_ce   : pend_3r_ce_q;
  assign src_3s_ce   = PIX_CE ? prom_3s_ce   : pend_3s_ce_q;

  always_ff @(posedge CLK_24M or posedge CLR) begin
    if (CLR) begin
      state_q        <= IDLE;
      pend_q         <= 1'b0;
      pend_3r_addr_q <= '0;
      pend_3s_addr_q <= '0;
      pend_3r_ce_q   <= 1'b0;
      pend_3s_ce_q   <= 1'b0;
      f3s_addr_q     <= '0;
      f3r_ce_q       <= 1'b0;
      f3s_ce_q       <= 1'b0;
      shadow_3r_q    <= '0;
      age_q          <= '0;
      mem_addr       <= '0;
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_wdata      <= '0;
      ld_ack         <= 1'b0;
      prom_3r_data   <= '0;
      prom_3s_data   <= '0;
      overrun        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      pend_3r_addr_q <= pend_3r_addr_d;
      pend_3s_addr_q <= pend_3s_addr_d;
      pend_3r_ce_q   <= pend_3r_ce_d;
      pend_3s_ce_q   <= pend_3s_ce_d;
      f3s_addr_q     <= f3s_addr_d;
      f3r_ce_q       <= f3r_ce_d;
      f3s_ce_q       <= f3s_ce_d;
      shadow_3r_q    <= shadow_3r_d;
      age_q          <= age_d;
      mem_addr       <= mem_addr_d;
      mem_rd         <= mem_rd_d;
      mem_wr         <= mem_wr_d;
      mem_wdata      <= mem_wdata_d;
      ld_ack         <= ld_ack_d;
      prom_3r_data   <= prom_3r_data_d;
      prom_3s_data   <= prom_3s_data_d;
      overrun        <= overrun_d;
    end
  end

  // Outputs are registered from the next-state decode, so each state's strobes
  // are visible during that state.
  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q;
    pend_3r_addr_d = pend_3r_addr_q;
    pend_3s_addr_d = pend_3s_addr_q;
    pend_3r_ce_d   = pend_3r_ce_q;
    pend_3s_ce_d   = pend_3s_ce_q;
    f3s_addr_d     = f3s_addr_q;
    f3r_ce_d       = f3r_ce_q;
    f3s_ce_d       = f3s_ce_q;
    shadow_3r_d    = shadow_3r_q;
    age_d          = age_q;
    mem_addr_d     = mem_addr;
    mem_rd_d       = 1'b0;
    mem_wr_d       = 1'b0;
    mem_wdata_d    = mem_wdata;
    ld_ack_d       = 1'b0;
    prom_3r_data_d = prom_3r_data;
    prom_3s_data_d = prom_3s_data;
    overrun_d      = overrun;

    if (PIX_CE && state_q != IDLE) begin
      pend_d         = 1'b1;
      pend_3r_addr_d = prom_3r_addr;
      pend_3s_addr_d = prom_3s_addr;
      pend_3r_ce_d   = prom_3r_ce;
      pend_3s_ce_d   = prom_3s_ce;
      if (state_q != WR) overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (PIX_CE || pend_q) begin
          state_d    = RD3R;
          pend_d     = 1'b0;
          f3r_ce_d   = src_3r_ce;
          f3s_ce_d   = src_3s_ce;
          f3s_addr_d = src_3s_addr;
          mem_rd_d   = src_3r_ce;
          mem_addr_d = BASE_3R + MEM_AW'(src_3r_addr);
        end else if (ld_req) begin
          state_d     = WR;
          mem_wr_d    = 1'b1;
          ld_ack_d    = 1'b1;
          mem_addr_d  = ld_addr;
          mem_wdata_d = ld_data;
        end
      end
      RD3R: begin
        state_d    = RD3S;
        mem_rd_d   = f3s_ce_q;
        mem_addr_d = BASE_3S + MEM_AW'(f3s_addr_q);
        age_d      = CW'(1);
      end
      RD3S, WAIT: begin
        // age counts clocks since the 3R issue; 3S data lands one clock after 3R.
        if (age_q == AGE_3R) shadow_3r_d = mem_rdata;
        age_d = age_q + CW'(1);
        if (state_q == RD3S) begin
          state_d = WAIT;
        end else if (age_q == AGE_3S) begin
          state_d = DONE;
          if (f3r_ce_q) prom_3r_data_d = shadow_3r_q;
          if (f3s_ce_q) prom_3s_data_d = mem_rdata[3:0];
        end
      end
      DONE:    state_d = IDLE;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_clut_prom_arbiter.sv
// tb_clut_prom_arbiter: two lanes (MEM_LATENCY 1 and 3, wrapping 3S base) driven with
// random fetch/load traffic; a cycle-stamped scoreboard checks memory strobes and data.
`timescale 1ns/1ps
module tb_clut_prom_arbiter;

  localparam int unsigned AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit lane_done [2];

  typedef struct packed {int unsigned cyc; logic [15:0] addr; logic [7:0] data;} ev_t;
  typedef struct packed {int unsigned cyc; logic [7:0] r; logic [3:0] s;} out_t;

  task automatic chk(input string name, input int lane_id, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL lane%0d %s: got %h required %h", lane_id, name, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned L   = (g == 0) ? 1 : 3;
    localparam logic [15:0] B3R = 16'h0000;
    localparam logic [15:0] B3S = (g == 0) ? 16'h0200 : 16'hFF00;
    localparam logic [8:0]  DA  = (g == 0) ? 9'h105 : 9'h1FF;
    localparam logic [15:0] P3R = B3R + 16'(DA);
    localparam logic [15:0] P3S = B3S + 16'(DA);

    logic        rst, pix, ce3r, ce3s, ld_req, ld_ack, mem_rd, mem_wr, ovr;
    logic [8:0]  a3r, a3s;
    logic [7:0]  r_data, ld_data, mem_wdata, mem_rdata;
    logic [3:0]  s_data;
    logic [15:0] ld_addr, mem_addr;

    clut_prom_arbiter #(.MEM_AW(AW), .BASE_3R(B3R), .BASE_3S(B3S), .MEM_LATENCY(L)) dut (
      .CLK_24M(clk), .CLR(rst), .PIX_CE(pix),
      .prom_3r_addr(a3r), .prom_3r_ce(ce3r), .prom_3r_data(r_data),
      .prom_3s_addr(a3s), .prom_3s_ce(ce3s), .prom_3s_data(s_data),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .overrun(ovr));

    // Memory device: fixed read latency, junk on the bus when no read is due.
    logic [7:0]  dev_mem [65536];
    logic [7:0]  ref_mem [65536];
    logic [7:0]  pipe [L];
    int unsigned cyc = 0;
    always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= (mem_rd === 1'b1) ? dev_mem[mem_addr] : 8'($urandom);
      if (mem_wr === 1'b1) dev_mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = pipe[L-1];

    // Reference model: expected strobes and output values stamped with their cycle.
    ev_t        rq[$];
    ev_t        wq[$];
    out_t       oq[$];
    logic [7:0] cur_r, mon_r;
    logic [3:0] cur_s, mon_s;
    bit         exp_ovr;

    task automatic m_fetch(input int unsigned c, input logic [8:0] ar, input logic cr,
                           input logic [8:0] as, input logic cs);
      logic [15:0] xr, xs;
      xr = B3R + 16'(ar);
      xs = B3S + 16'(as);
      if (cr) begin rq.push_back('{c + 1, xr, 8'h00}); cur_r = ref_mem[xr]; end
      if (cs) begin rq.push_back('{c + 2, xs, 8'h00}); cur_s = ref_mem[xs][3:0]; end
      oq.push_back('{c + 3 + L, cur_r, cur_s});
    endtask

    task automatic m_write(input int unsigned c, input logic [15:0] a, input logic [7:0] d);
      wq.push_back('{c, a, d});
      ref_mem[a] = d;
    endtask

    always @(negedge clk) begin
      bit   er, ew;
      ev_t  e;
      out_t o;
      if (rst === 1'b0) begin
        er = (rq.size() != 0) && (rq[0].cyc == cyc);
        if (mem_rd !== 1'b0 || er) begin
          e = '0;
          if (er) e = rq.pop_front();
          chk("mem read {rd,addr}", g, 64'({mem_rd, mem_addr}), 64'({er, e.addr}));
        end
        ew = (wq.size() != 0) && (wq[0].cyc == cyc);
        if (mem_wr !== 1'b0 || ld_ack !== 1'b0 || ew) begin
          e = '0;
          if (ew) e = wq.pop_front();
          chk("mem write {wr,ack,addr,data}", g, 64'({mem_wr, ld_ack, mem_addr, mem_wdata}),
              64'({ew, ew, e.addr, e.data}));
        end
        if (oq.size() != 0 && oq[0].cyc == cyc + 1)
          chk("data held before update", g, 64'({r_data, s_data}), 64'({mon_r, mon_s}));
        if (oq.size() != 0 && oq[0].cyc == cyc) begin
          o = oq.pop_front();
          mon_r = o.r;
          mon_s = o.s;
          chk("data update {3r,3s}", g, 64'({r_data, s_data}), 64'({mon_r, mon_s}));
        end
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic idle_inputs();
      pix  = 1'b0;
      a3r  = 9'($urandom);
      a3s  = 9'($urandom);
      ce3r = 1'($urandom);
      ce3s = 1'($urandom);
    endtask

    task automatic strobe(input logic [8:0] ar, input logic cr, input logic [8:0] as,
                          input logic cs);
      pix = 1'b1; a3r = ar; ce3r = cr; a3s = as; ce3s = cs;
    endtask

    task automatic fetch_once(input logic [8:0] ar, input logic cr, input logic [8:0] as,
                              input logic cs);
      int unsigned c;
      c = cyc;
      strobe(ar, cr, as, cs);
      m_fetch(c, ar, cr, as, cs);
      tick();
      idle_inputs();
      while (cyc < c + 4 + L) tick();
    endtask

    task automatic wait_ack();
      int n = 0;
      while (ld_ack !== 1'b1 && n < 20) begin tick(); n++; end
      if (ld_ack !== 1'b1) begin
        n_chk++;
        n_fail++;
        $display("FAIL lane%0d ld_ack timeout: got none within 20 clocks, required a pulse", g);
      end
      tick();
      ld_req = 1'b0;
    endtask

    task automatic rand_write(output logic [15:0] a, output logic [7:0] d);
      case ($urandom_range(0, 2))
        0:       a = B3R + 16'($urandom_range(0, 511));
        1:       a = B3S + 16'($urandom_range(0, 511));
        default: a = 16'($urandom);
      endcase
      d = 8'($urandom);
    endtask

    initial begin
      int unsigned c, d1;
      bit          third;
      logic [8:0]  ar, as;
      logic        cr, cs;
      logic [15:0] wa;
      logic [7:0]  wd;
      rst = 1'b1; ld_req = 1'b0; ld_addr = '0; ld_data = '0;
      idle_inputs();
      for (int i = 0; i < 65536; i++) begin
        dev_mem[i] = 8'($urandom);
        ref_mem[i] = dev_mem[i];
      end
      dev_mem[P3R] = 8'hA5;              ref_mem[P3R] = 8'hA5;
      dev_mem[P3S] = 8'h0C;              ref_mem[P3S] = 8'h0C;
      dev_mem[B3S + 16'h0033] = 8'h57;   ref_mem[B3S + 16'h0033] = 8'h57;
      cur_r = '0; cur_s = '0; mon_r = '0; mon_s = '0; exp_ovr = 1'b0;
      repeat (3) tick();
      chk("reset outputs", g,
          64'({r_data, s_data, ld_ack, mem_addr, mem_rd, mem_wr, mem_wdata, ovr}), 64'(0));
      rst = 1'b0;
      tick();

      fetch_once(DA, 1'b1, DA, 1'b1);
      chk("directed 3r byte", g, 64'(r_data), 64'(8'hA5));
      chk("directed 3s nibble", g, 64'(s_data), 64'(4'hC));
      fetch_once(9'h033, 1'b1, 9'h033, 1'b1);
      fetch_once(9'h0AB, 1'b1, 9'h1AB, 1'b0);
      chk("3s held with ce=0", g, 64'(s_data), 64'(4'h7));

      for (int it = 0; it < 36; it++) begin
        ar = 9'($urandom); as = 9'($urandom); cr = 1'($urandom); cs = 1'($urandom);
        case ($urandom_range(0, 5))
          0: fetch_once(ar, cr, as, cs);
          1: begin
            c = cyc;
            rand_write(wa, wd);
            ld_req = 1'b1; ld_addr = wa; ld_data = wd;
            m_write(c + 1, wa, wd);
            wait_ack();
          end
          2: begin
            c = cyc;
            rand_write(wa, wd);
            strobe(ar, cr, as, cs);
            ld_req = 1'b1; ld_addr = wa; ld_data = wd;
            m_fetch(c, ar, cr, as, cs);
            m_write(c + 5 + L, wa, wd);
            tick();
            idle_inputs();
            wait_ack();
          end
          3: begin
            c = cyc;
            strobe(ar, cr, as, cs);
            m_fetch(c, ar, cr, as, cs);
            d1 = $urandom_range(1, 3 + L);
            third = (d1 < 3 + L) && ($urandom_range(0, 1) == 1);
            tick();
            idle_inputs();
            while (cyc < c + d1) tick();
            ar = 9'($urandom); as = 9'($urandom); cr = 1'($urandom); cs = 1'($urandom);
            strobe(ar, cr, as, cs);
            tick();
            idle_inputs();
            if (third) begin
              while (cyc < c + 3 + L) tick();
              ar = 9'($urandom); as = 9'($urandom); cr = 1'($urandom); cs = 1'($urandom);
              strobe(ar, cr, as, cs);
              tick();
              idle_inputs();
            end
            m_fetch(c + 4 + L, ar, cr, as, cs);
            exp_ovr = 1'b1;
            while (cyc < c + 8 + 2 * L) tick();
          end
          4: begin
            c = cyc;
            rand_write(wa, wd);
            ld_req = 1'b1; ld_addr = wa; ld_data = wd;
            m_write(c + 1, wa, wd);
            tick();
            strobe(ar, cr, as, cs);
            m_fetch(c + 2, ar, cr, as, cs);
            tick();
            idle_inputs();
            ld_req = 1'b0;
            while (cyc < c + 6 + L) tick();
          end
          default: begin
            c = cyc;
            strobe(ar, 1'b1, as, 1'b1);
            m_fetch(c, ar, 1'b1, as, 1'b1);
            tick();
            idle_inputs();
            while (cyc < c + 3) tick();
            rst = 1'b1;
            oq.delete();
            cur_r = '0; cur_s = '0; mon_r = '0; mon_s = '0; exp_ovr = 1'b0;
            #1;
            chk("async clear mid-fetch", g,
                64'({r_data, s_data, ld_ack, mem_addr, mem_rd, mem_wr, mem_wdata, ovr}), 64'(0));
            tick();
            rst = 1'b0;
            tick();
          end
        endcase
        chk("overrun flag", g, 64'(ovr), 64'(exp_ovr));
      end

      repeat (12) tick();
      chk("scoreboard drained", g, 64'(rq.size() + wq.size() + oq.size()), 64'(0));
      lane_done[g] = 1'b1;
    end
  end

  initial begin
    wait (lane_done[0] && lane_done[1]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: lanes still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
